// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line comes out of reset idle.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling on a clock-count bit timer, one-cycle
// done / framing-error strobes, break lockout until the line returns high.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      RX_in,
  output logic [UART_DATA_BITS-1:0] RX_data_out,
  output logic                      RXdone,
  output logic                      RXframe_err,
  output logic                      RXbusy
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_ONE = 3'd1;
  localparam logic [2:0]    IDX_END = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_r, state_n;
  logic [CW-1:0]             cnt_r, cnt_n;
  logic [2:0]                idx_r, idx_n;
  logic [UART_DATA_BITS-1:0] shift_r, shift_n;
  logic [UART_DATA_BITS-1:0] data_r, data_n;
  logic                      done_r, done_n;
  logic                      ferr_r, ferr_n;
  logic                      busy_r, busy_n;
  logic                      line_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (RX_in),
    .q       (line_s)
  );

  // Next-state, bit timer, shifter and strobe decode
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r + CNT_ONE;
    idx_n   = idx_r;
    shift_n = shift_r;
    data_n  = data_r;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    busy_n  = busy_r;
    case (state_r)
      IDLE: begin
        cnt_n = '0;
        if (!line_s) begin
          state_n = START;
          idx_n   = 3'd0;
          busy_n  = 1'b1;
        end else begin
          busy_n  = 1'b0;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_n = '0;
          if (line_s) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_n   = '0;
          shift_n = {line_s, shift_r[UART_DATA_BITS-1:1]};
          if (idx_r == IDX_END) begin
            state_n = STOP;
          end else begin
            idx_n   = idx_r + IDX_ONE;
          end
        end else begin
          state_n = DATA;
        end
      end
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_n  = '0;
          busy_n = 1'b0;
          if (line_s) begin
            data_n  = shift_r;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          state_n = STOP;
        end
      end
      // A held-low break parks here so it cannot retrigger a new frame
      WAIT_HIGH: begin
        cnt_n  = '0;
        busy_n = 1'b0;
        if (line_s) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT_HIGH;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered output update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= '0;
      data_r  <= '0;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
      data_r  <= data_n;
      done_r  <= done_n;
      ferr_r  <= ferr_n;
      busy_r  <= busy_n;
    end
  end

  assign RX_data_out = data_r;
  assign RXdone      = done_r;
  assign RXframe_err = ferr_r;
  assign RXbusy      = busy_r;

endmodule
